// File: rtl/dpram_arb.sv
// Round-robin two-master arbiter for port B of the byte-writable dpram.
// One RAM access per cycle; registered read valids are steered back to the issuing master.
//
// state      | meaning
// -----------+---------------------------------------------------------------
// last_q     | master granted most recently (1 after reset, so m0 wins first)
// hold_v_q   | a locked grant is in force for hold_own_q
// hold_own_q | master owning the lock
// lock_cnt_q | consecutive locked grants to the owner, saturates at LOCK_MAX
// rd_pend_q  | per-master read issued last cycle (drives rvalid)
module dpram_arb #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_COL    = 4,
  parameter int LOCK_MAX   = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  m0_req,
  input  logic                  m1_req,
  input  logic                  m0_lock,
  input  logic                  m1_lock,
  input  logic [NUM_COL-1:0]    m0_we,
  input  logic [NUM_COL-1:0]    m1_we,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m0_din,
  input  logic [DATA_WIDTH-1:0] m1_din,
  output logic                  m0_gnt,
  output logic                  m1_gnt,
  output logic [DATA_WIDTH-1:0] m0_dout,
  output logic [DATA_WIDTH-1:0] m1_dout,
  output logic                  m0_rvalid,
  output logic                  m1_rvalid,
  output logic                  enaB,
  output logic [NUM_COL-1:0]    weB,
  output logic [ADDR_WIDTH-1:0] addrB,
  output logic [DATA_WIDTH-1:0] dinB,
  input  logic [DATA_WIDTH-1:0] doutB
);

  localparam int CNT_W = $clog2(LOCK_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_MAX);

  logic             last_q, last_d;
  logic             hold_v_q, hold_v_d;
  logic             hold_own_q, hold_own_d;
  logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;
  logic [1:0]       rd_pend_q, rd_pend_d;

  logic gnt0, gnt1;
  logic owner_req, hold_ok, gnt_lock;

  always_comb begin
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    owner_req = hold_own_q ? m1_req : m0_req;
    hold_ok   = hold_v_q && owner_req && (lock_cnt_q < CNT_MAX);
    if (!reset) begin
      if (hold_ok) begin
        gnt0 = !hold_own_q;
        gnt1 = hold_own_q;
      end else if (m0_req && m1_req) begin
        gnt0 = last_q;
        gnt1 = !last_q;
      end else begin
        gnt0 = m0_req;
        gnt1 = m1_req;
      end
    end
  end

  // Idle cycles leave addrB/dinB on m0's command; only enaB/weB matter then.
  always_comb begin
    m0_gnt    = gnt0;
    m1_gnt    = gnt1;
    enaB      = gnt0 | gnt1;
    weB       = '0;
    addrB     = m0_addr;
    dinB      = m0_din;
    if (gnt1) begin
      weB   = m1_we;
      addrB = m1_addr;
      dinB  = m1_din;
    end else if (gnt0) begin
      weB = m0_we;
    end
    m0_dout   = doutB;
    m1_dout   = doutB;
    m0_rvalid = rd_pend_q[0];
    m1_rvalid = rd_pend_q[1];
  end

  always_comb begin
    last_d     = last_q;
    hold_v_d   = 1'b0;
    hold_own_d = hold_own_q;
    lock_cnt_d = '0;
    gnt_lock   = gnt1 ? m1_lock : m0_lock;
    rd_pend_d  = {gnt1 && (m1_we == '0), gnt0 && (m0_we == '0)};
    if (gnt0 || gnt1) begin
      last_d = gnt1;
      if (gnt_lock) begin
        hold_v_d   = 1'b1;
        hold_own_d = gnt1;
        if (hold_v_q && (hold_own_q == gnt1)) begin
          lock_cnt_d = (lock_cnt_q == CNT_MAX) ? CNT_MAX : lock_cnt_q + 1'b1;
        end else begin
          lock_cnt_d = CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_q     <= 1'b1;
      hold_v_q   <= 1'b0;
      hold_own_q <= 1'b0;
      lock_cnt_q <= '0;
      rd_pend_q  <= '0;
    end else begin
      last_q     <= last_d;
      hold_v_q   <= hold_v_d;
      hold_own_q <= hold_own_d;
      lock_cnt_q <= lock_cnt_d;
      rd_pend_q  <= rd_pend_d;
    end
  end

endmodule

// File: tb/tb_dpram_arb.sv
// Bench for dpram_arb: directed scenarios plus randomized traffic against a
// transaction-level model of the arbitration rules and a shadow memory.
module tb_dpram_arb;
  localparam int AW = 12;
  localparam int DW = 32;
  localparam int NC = 4;
  localparam int LM = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          m0_req, m1_req, m0_lock, m1_lock;
  logic [NC-1:0] m0_we, m1_we;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_din, m1_din;
  logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, enaB;
  logic [DW-1:0] m0_dout, m1_dout, dinB, doutB;
  logic [NC-1:0] weB;
  logic [AW-1:0] addrB;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  dpram_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_COL(NC), .LOCK_MAX(LM)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m1_req(m1_req), .m0_lock(m0_lock), .m1_lock(m1_lock),
    .m0_we(m0_we), .m1_we(m1_we), .m0_addr(m0_addr), .m1_addr(m1_addr),
    .m0_din(m0_din), .m1_din(m1_din), .m0_gnt(m0_gnt), .m1_gnt(m1_gnt),
    .m0_dout(m0_dout), .m1_dout(m1_dout), .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid),
    .enaB(enaB), .weB(weB), .addrB(addrB), .dinB(dinB), .doutB(doutB)
  );

  function automatic logic [DW-1:0] init_word(input int i);
    if (i == 16) return 32'hDEADBEEF;
    if (i == 32) return 32'hAABBCCDD;
    return 32'h5A000000 + 32'(i) * 32'h00010203;
  endfunction

  // RAM port B stand-in: one-cycle read latency, byte-writable, reloaded during reset.
  logic [DW-1:0] ram [0:63];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 64; i++) ram[i] <= init_word(i);
    end else if (enaB) begin
      for (int c = 0; c < NC; c++)
        if (weB[c]) ram[addrB[5:0]][c*8 +: 8] <= dinB[c*8 +: 8];
      if (weB == '0) doutB <= ram[addrB[5:0]];
    end
  end

  // Reference model: who wins, how long a lock streak has run, what each read returns.
  int            mdl_last, mdl_owner, mdl_streak;
  logic          exp_rv [2];
  logic [DW-1:0] exp_data;
  logic [DW-1:0] shadow [0:63];

  task automatic model_reset();
    mdl_last = 1; mdl_owner = -1; mdl_streak = 0;
    exp_rv[0] = 1'b0; exp_rv[1] = 1'b0; exp_data = '0;
    for (int i = 0; i < 64; i++) shadow[i] = init_word(i);
  endtask

  function automatic int exp_grant(input logic r0, input logic r1);
    logic r [2];
    r[0] = r0; r[1] = r1;
    if (mdl_owner >= 0 && r[mdl_owner] && mdl_streak < LM) return mdl_owner;
    if (r0 && r1) return 1 - mdl_last;
    if (r0) return 0;
    if (r1) return 1;
    return -1;
  endfunction

  task automatic model_commit(input int g, input logic lk, input logic [NC-1:0] we,
                              input logic [5:0] a, input logic [DW-1:0] d);
    exp_rv[0] = 1'b0; exp_rv[1] = 1'b0;
    if (g < 0) begin
      mdl_owner = -1; mdl_streak = 0;
      return;
    end
    mdl_last = g;
    if (lk) begin
      mdl_streak = (mdl_owner == g) ? ((mdl_streak < LM) ? mdl_streak + 1 : LM) : 1;
      mdl_owner  = g;
    end else begin
      mdl_owner = -1; mdl_streak = 0;
    end
    if (we == '0) begin
      exp_rv[g] = 1'b1;
      exp_data  = shadow[a];
    end else begin
      for (int c = 0; c < NC; c++)
        if (we[c]) shadow[a][c*8 +: 8] = d[c*8 +: 8];
    end
  endtask

  task automatic drive(input logic r0, input logic l0, input logic [NC-1:0] w0,
                       input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                       input logic r1, input logic l1, input logic [NC-1:0] w1,
                       input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    m0_req = r0; m0_lock = l0; m0_we = w0; m0_addr = a0; m0_din = d0;
    m1_req = r1; m1_lock = l1; m1_we = w1; m1_addr = a1; m1_din = d1;
  endtask

  task automatic idle();
    drive(0, 0, '0, '0, '0, 0, 0, '0, '0, '0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle();
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    drive(1, 1, 4'hF, 12'h010, 32'h1, 1, 1, 4'h3, 12'h020, 32'h2);
    @(negedge clk);
    #2;
    n_checks++;
    if (m0_gnt !== 1'b0 || m1_gnt !== 1'b0) begin
      n_fail++; $display("FAIL reset_gnt: got m0=%b m1=%b, want 0/0", m0_gnt, m1_gnt);
    end
    n_checks++;
    if (enaB !== 1'b0 || weB !== 4'h0) begin
      n_fail++; $display("FAIL reset_ena: got enaB=%b weB=%h, want 0/0", enaB, weB);
    end
    n_checks++;
    if (m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0) begin
      n_fail++; $display("FAIL reset_rvalid: got m0=%b m1=%b, want 0/0", m0_rvalid, m1_rvalid);
    end
    do_reset();
  endtask

  task automatic test_single_read();
    do_reset();
    drive(1, 0, 4'h0, 12'h010, '0, 0, 0, '0, '0, '0);
    #2;
    n_checks++;
    if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0 || enaB !== 1'b1 || addrB !== 12'h010) begin
      n_fail++;
      $display("FAIL single_gnt: got gnt=%b%b enaB=%b addrB=%h, want m0 granted at 010",
               m1_gnt, m0_gnt, enaB, addrB);
    end
    @(negedge clk);
    idle();
    #2;
    n_checks++;
    if (m0_rvalid !== 1'b1 || m1_rvalid !== 1'b0 || m0_dout !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL single_data: got rv=%b%b dout=%h, want m0 rvalid with DEADBEEF",
               m1_rvalid, m0_rvalid, m0_dout);
    end
    @(negedge clk);
  endtask

  task automatic test_contention();
    logic prev0;
    do_reset();
    prev0 = 1'b0;
    for (int i = 0; i < 7; i++) begin
      if (i < 6) drive(1, 0, '0, 12'h010, '0, 1, 0, '0, 12'h020, '0);
      else idle();
      #2;
      if (i < 6) begin
        n_checks++;
        if (m0_gnt !== (i % 2 == 0) || m1_gnt !== (i % 2 == 1)) begin
          n_fail++;
          $display("FAIL contend_gnt[%0d]: got m0=%b m1=%b, want m%0d", i, m0_gnt, m1_gnt, i % 2);
        end
      end
      if (i > 0) begin
        n_checks++;
        if (m0_rvalid !== prev0 || m1_rvalid !== !prev0 ||
            (prev0 ? m0_dout : m1_dout) !== (prev0 ? 32'hDEADBEEF : 32'hAABBCCDD)) begin
          n_fail++;
          $display("FAIL contend_rv[%0d]: got rv=%b%b dout=%h, want rv for m%0d",
                   i, m1_rvalid, m0_rvalid, doutB, prev0 ? 0 : 1);
        end
      end
      prev0 = (i % 2 == 0);
      @(negedge clk);
    end
  endtask

  task automatic test_byte_write();
    do_reset();
    drive(0, 0, '0, '0, '0, 1, 0, 4'b0101, 12'h020, 32'h11223344);
    #2;
    n_checks++;
    if (m1_gnt !== 1'b1 || weB !== 4'b0101 || dinB !== 32'h11223344 || addrB !== 12'h020) begin
      n_fail++;
      $display("FAIL bw_write: got gnt1=%b weB=%b dinB=%h addrB=%h, want 1/0101/11223344/020",
               m1_gnt, weB, dinB, addrB);
    end
    @(negedge clk);
    drive(1, 0, '0, 12'h020, '0, 0, 0, '0, '0, '0);
    #2;
    n_checks++;
    if (m0_gnt !== 1'b1 || m1_rvalid !== 1'b0) begin
      n_fail++; $display("FAIL bw_read: got gnt0=%b m1_rvalid=%b, want 1/0", m0_gnt, m1_rvalid);
    end
    @(negedge clk);
    idle();
    #2;
    n_checks++;
    if (m0_rvalid !== 1'b1 || m1_rvalid !== 1'b0 || m0_dout !== 32'hAA22CC44) begin
      n_fail++;
      $display("FAIL bw_data: got rv=%b%b dout=%h, want m0 rvalid with AA22CC44",
               m1_rvalid, m0_rvalid, m0_dout);
    end
    @(negedge clk);
  endtask

  task automatic test_lock_cap();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      drive(1, 1, '0, 12'h010, '0, 1, 0, '0, 12'h020, '0);
      #2;
      n_checks++;
      if (m0_gnt !== (i != 8) || m1_gnt !== (i == 8)) begin
        n_fail++;
        $display("FAIL lockcap[%0d]: got m0=%b m1=%b, want m%0d", i, m0_gnt, m1_gnt, (i == 8) ? 1 : 0);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_lock_nocontend();
    do_reset();
    for (int i = 0; i < 13; i++) begin
      drive(i == 12, 0, '0, 12'h010, '0, 1, 1, '0, 12'h020, '0);
      #2;
      n_checks++;
      if (m0_gnt !== (i == 12) || m1_gnt !== (i != 12)) begin
        n_fail++;
        $display("FAIL locksat[%0d]: got m0=%b m1=%b, want m%0d", i, m0_gnt, m1_gnt, (i == 12) ? 0 : 1);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_read();
    do_reset();
    drive(1, 0, '0, 12'h010, '0, 0, 0, '0, '0, '0);
    #2;
    n_checks++;
    if (m0_gnt !== 1'b1) begin
      n_fail++; $display("FAIL midrst_gnt: got %b, want 1", m0_gnt);
    end
    @(posedge clk);
    #1;
    idle();
    reset = 1'b1;
    #1;
    n_checks++;
    if (m0_rvalid !== 1'b0) begin
      n_fail++; $display("FAIL midrst_drop: got m0_rvalid=%b, want 0", m0_rvalid);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #2;
      n_checks++;
      if (m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0) begin
        n_fail++; $display("FAIL midrst_late[%0d]: got rv=%b%b, want 00", i, m1_rvalid, m0_rvalid);
      end
      @(negedge clk);
    end
    drive(1, 0, '0, 12'h011, '0, 1, 0, '0, 12'h021, '0);
    #2;
    n_checks++;
    if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0) begin
      n_fail++; $display("FAIL midrst_rr: got m0=%b m1=%b, want m0", m0_gnt, m1_gnt);
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    logic          pr [2], pl [2], sticky [2];
    logic [NC-1:0] pw [2];
    logic [AW-1:0] pa [2];
    logic [DW-1:0] pd [2];
    int            eg;
    do_reset();
    model_reset();
    for (int m = 0; m < 2; m++) begin
      pr[m] = 0; pl[m] = 0; sticky[m] = 0; pw[m] = '0; pa[m] = '0; pd[m] = '0;
    end
    for (int cyc = 0; cyc < 800; cyc++) begin
      for (int m = 0; m < 2; m++) begin
        if (!pr[m]) begin
          if (sticky[m] ? ($urandom_range(0, 15) != 0) : ($urandom_range(0, 3) != 0)) begin
            pr[m] = 1'b1;
            pl[m] = sticky[m] ? ($urandom_range(0, 7) != 0) : 1'($urandom_range(0, 1));
            pw[m] = ($urandom_range(0, 2) == 0) ? NC'($urandom) : '0;
            pa[m] = AW'($urandom_range(0, 15));
            pd[m] = $urandom;
          end
        end else if ($urandom_range(0, 31) == 0) begin
          pr[m] = 1'b0;
          sticky[m] = 1'b0;
        end
      end
      drive(pr[0], pl[0], pw[0], pa[0], pd[0], pr[1], pl[1], pw[1], pa[1], pd[1]);
      #2;
      eg = exp_grant(pr[0], pr[1]);
      n_checks++;
      if (m0_rvalid !== exp_rv[0] || m1_rvalid !== exp_rv[1]) begin
        n_fail++;
        $display("FAIL rnd_rvalid[%0d]: got %b%b, want %b%b", cyc, m1_rvalid, m0_rvalid, exp_rv[1], exp_rv[0]);
      end
      if (exp_rv[0] || exp_rv[1]) begin
        n_checks++;
        if ((exp_rv[0] ? m0_dout : m1_dout) !== exp_data) begin
          n_fail++; $display("FAIL rnd_data[%0d]: got %h, want %h", cyc, doutB, exp_data);
        end
      end
      n_checks++;
      if (m0_gnt !== (eg == 0) || m1_gnt !== (eg == 1) || enaB !== (eg >= 0)) begin
        n_fail++;
        $display("FAIL rnd_gnt[%0d]: got m0=%b m1=%b enaB=%b, want grant %0d", cyc, m0_gnt, m1_gnt, enaB, eg);
      end
      if (eg >= 0) begin
        n_checks++;
        if (addrB !== pa[eg] || weB !== pw[eg] || (pw[eg] != '0 && dinB !== pd[eg])) begin
          n_fail++;
          $display("FAIL rnd_cmd[%0d]: got addr=%h we=%b din=%h, want %h/%b/%h",
                   cyc, addrB, weB, dinB, pa[eg], pw[eg], pd[eg]);
        end
        model_commit(eg, pl[eg], pw[eg], pa[eg][5:0], pd[eg]);
        sticky[eg] = pl[eg];
        pr[eg] = 1'b0;
      end else begin
        model_commit(-1, 1'b0, '0, '0, '0);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_contention();
    test_byte_write();
    test_lock_cap();
    test_lock_nocontend();
    test_reset_mid_read();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
